// File: rtl/mem_fill_arbiter_pkg.sv
// Shared definitions for the I/D cache memory-fill arbiter: FSM states, owner
// encoding and block geometry.
package mem_fill_arbiter_pkg;

  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned WIDX_W        = $clog2(WORDS_PER_BLK);
  localparam int unsigned BLK_OFF_W     = WIDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_fill_arbiter_rr_arb2.sv
// Two-way round-robin picker between I and D requesters; remembers the side
// granted last and favours the other one on a tie.
module mem_rr_arb2
  import mem_fill_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   take,
  output owner_e pick
);

  owner_e last_q, last_d;

  always_comb begin
    pick = OWN_I;
    if (req_d && (!req_i || (last_q == OWN_I))) pick = OWN_D;
    last_d = last_q;
    if (take) last_d = pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_I;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Sequences the shared main memory between I-cache block fills and D-cache
// block fills / single-word write-throughs.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned WORDS_PER_BLK = mem_fill_arbiter_pkg::WORDS_PER_BLK,
  parameter int unsigned MEM_LAT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  output logic [WIDX_W-1:0] i_word_idx,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic [WIDX_W-1:0] d_word_idx,
  output logic              d_done,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy
);

  localparam int unsigned BLK_W         = ADDR_W - BLK_OFF_W;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_BLK - 1);
  // Read latency is a property of the memory; the fill simply counts returns.
  localparam int unsigned unused_mem_lat = MEM_LAT;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [WIDX_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [WIDX_W-1:0] rcv_cnt_q, rcv_cnt_d;

  owner_e arb_pick;
  logic   arb_take;
  logic   rx;
  logic   last_rx;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^i_addr[BLK_OFF_W-1:0];

  mem_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req_i (i_req),
    .req_d (d_req),
    .take  (arb_take),
    .pick  (arb_pick)
  );

  // Returns are accepted in ISSUE too: early words overlap the tail of issue.
  assign rx      = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && mem_valid;
  assign last_rx = (state_q == ST_DRAIN) && mem_valid && (rcv_cnt_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    blk_d     = blk_q;
    iss_cnt_d = iss_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    arb_take  = 1'b0;
    if (rx) rcv_cnt_d = rcv_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          arb_take  = 1'b1;
          owner_d   = arb_pick;
          iss_cnt_d = '0;
          rcv_cnt_d = '0;
          if (arb_pick == OWN_D) begin
            blk_d   = d_addr[ADDR_W-1:BLK_OFF_W];
            state_d = d_wr ? ST_WRITE : ST_ISSUE;
          end else begin
            blk_d   = i_addr[ADDR_W-1:BLK_OFF_W];
            state_d = ST_ISSUE;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ISSUE: begin
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_q == LAST_IDX) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (last_rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      blk_q     <= '0;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      blk_q     <= blk_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign i_grant   = busy && (owner_q == OWN_I);
  assign d_grant   = busy && (owner_q == OWN_D);
  assign mem_en    = (state_q == ST_ISSUE) || (state_q == ST_WRITE);
  assign mem_wr    = (state_q == ST_WRITE);
  assign mem_addr  = (state_q == ST_WRITE) ? d_addr :
                     (state_q == ST_ISSUE) ? {blk_q, iss_cnt_q, 1'b0} : '0;
  assign mem_wdata = (state_q == ST_WRITE) ? d_wdata : '0;
  assign fill_data = mem_rdata;

  assign i_data_valid = rx && (owner_q == OWN_I);
  assign d_data_valid = rx && (owner_q == OWN_D);
  assign i_word_idx   = i_data_valid ? rcv_cnt_q : '0;
  assign d_word_idx   = d_data_valid ? rcv_cnt_q : '0;
  assign i_done       = last_rx && (owner_q == OWN_I);
  assign d_done       = (last_rx && (owner_q == OWN_D)) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter with a small pipelined memory model.
module tb_mem_fill_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_grant, i_data_valid, i_done;
  logic [AW-1:0] i_addr;
  logic [2:0]    i_word_idx;
  logic          d_req, d_wr, d_grant, d_data_valid, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_word_idx;
  logic [DW-1:0] fill_data, mem_wdata, mem_rdata;
  logic          mem_en, mem_wr, mem_valid, busy;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct packed {
    logic          done;
    logic [2:0]    idx;
    logic [DW-1:0] data;
  } side_exp_t;

  mem_exp_t  mem_q[$];
  side_exp_t i_q[$];
  side_exp_t d_q[$];

  always #5 clk = ~clk;

  mem_fill_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLK(8), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .i_word_idx(i_word_idx), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
    .d_data_valid(d_data_valid), .d_word_idx(d_word_idx), .d_done(d_done),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
  );

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // memory model: read issued in cycle t returns data in cycle t+LAT
  logic [LAT-1:0] vpipe;
  logic [AW-1:0]  apipe[LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
      for (int k = 0; k < LAT; k++) apipe[k] <= '0;
    end else begin
      vpipe    <= {vpipe[LAT-2:0], mem_en & ~mem_wr};
      apipe[0] <= mem_addr;
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
  end
  assign mem_valid = vpipe[LAT-1];
  assign mem_rdata = mem_valid ? mdata(apipe[LAT-1]) : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_fill(input bit side_d, input logic [AW-1:0] addr);
    for (int k = 0; k < 8; k++) begin
      logic [AW-1:0] wa;
      logic [2:0]    kk;
      kk = 3'(k);
      wa = {addr[AW-1:4], kk, 1'b0};
      mem_q.push_back('{wr: 1'b0, addr: wa, data: '0});
      if (side_d) d_q.push_back('{done: 1'b0, idx: kk, data: mdata(wa)});
      else        i_q.push_back('{done: 1'b0, idx: kk, data: mdata(wa)});
    end
    if (side_d) d_q.push_back('{done: 1'b1, idx: 3'd0, data: '0});
    else        i_q.push_back('{done: 1'b1, idx: 3'd0, data: '0});
  endtask

  task automatic side_mon(input bit is_d, input logic dv, input logic dn, input logic [2:0] idx);
    side_exp_t e;
    bit        have;
    string     tag;
    tag = is_d ? "d" : "i";
    if (dv) begin
      if (is_d) have = (d_q.size() > 0) && !d_q[0].done;
      else      have = (i_q.size() > 0) && !i_q[0].done;
      if (!have) chk({tag, "_extra_data_valid"}, dv, 0);
      else begin
        if (is_d) e = d_q.pop_front();
        else      e = i_q.pop_front();
        chk({tag, "_word_idx"}, idx, e.idx);
        chk({tag, "_fill_data"}, fill_data, e.data);
      end
    end
    if (dn) begin
      if (is_d) have = (d_q.size() > 0) && d_q[0].done;
      else      have = (i_q.size() > 0) && i_q[0].done;
      if (!have) chk({tag, "_extra_done"}, dn, 0);
      else begin
        if (is_d) e = d_q.pop_front();
        else      e = i_q.pop_front();
        chk({tag, "_done"}, dn, 1);
      end
    end
  endtask

  // monitor: compares whatever the DUT presents against the expected queues
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mem_exp_t me;
      if (mem_en) begin
        if (mem_q.size() == 0) chk("mem_extra_en", mem_en, 0);
        else begin
          me = mem_q.pop_front();
          chk("mem_wr", mem_wr, me.wr);
          chk("mem_addr", mem_addr, me.addr);
          if (me.wr) chk("mem_wdata", mem_wdata, me.data);
        end
      end else if (mem_wr) chk("mem_wr_without_en", mem_wr, 0);
      side_mon(1'b0, i_data_valid, i_done, i_word_idx);
      side_mon(1'b1, d_data_valid, d_done, d_word_idx);
      if (busy) chk("single_grant", i_grant ^ d_grant, 1);
      else      chk("idle_no_grant", {i_grant, d_grant}, 0);
    end
  end

  task automatic run_until_quiet(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((i_req || d_req || busy || mem_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    chk({tag, "_quiet"}, {i_req, d_req, busy, mem_q.size() != 0, i_q.size() != 0, d_q.size() != 0}, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, {i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done,
                        mem_en, mem_wr, busy}, 0);
    chk({tag, "_bus"}, {mem_addr, mem_wdata}, 0);
    chk({tag, "_idx"}, {i_word_idx, d_word_idx}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned cnt;
    bit          seen;
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;

    // 1: lone I fill
    @(negedge clk);
    push_fill(1'b0, 16'h1234);
    i_addr = 16'h1234; i_req = 1'b1;
    run_until_quiet("t1", 40);

    // 2: tie straight after reset goes to D, I follows after one IDLE cycle
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_fill(1'b1, 16'h0208);
    push_fill(1'b0, 16'h0100);
    d_addr = 16'h0208; d_wr = 1'b0; d_req = 1'b1;
    i_addr = 16'h0100; i_req = 1'b1;
    @(negedge clk);
    chk("t2_first_grant", {d_grant, i_grant}, 2'b10);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (d_done) begin seen = 1'b1; d_req = 1'b0; end
    end
    chk("t2_d_done_seen", seen, 1);
    @(negedge clk);
    chk("t2_idle_gap", {busy, i_grant}, 0);
    @(negedge clk);
    chk("t2_i_granted", i_grant, 1);
    run_until_quiet("t2", 40);

    // 3: two further ties keep alternating D, I, D, I
    for (int r = 0; r < 2; r++) begin
      logic [AW-1:0] da, ia;
      da = 16'h3010 + AW'(r * 16'h0100);
      ia = 16'h4020 + AW'(r * 16'h0100);
      push_fill(1'b1, da);
      push_fill(1'b0, ia);
      d_addr = da; d_wr = 1'b0; d_req = 1'b1;
      i_addr = ia; i_req = 1'b1;
      run_until_quiet("t3", 80);
    end

    // 4: single-word write-through
    mem_q.push_back('{wr: 1'b1, addr: 16'h0040, data: 16'hBEEF});
    d_q.push_back('{done: 1'b1, idx: 3'd0, data: '0});
    d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    run_until_quiet("t4", 20);
    d_wr = 1'b0;

    // 5: reset after three words of a D fill, then a clean restart
    push_fill(1'b1, 16'h2A56);
    d_addr = 16'h2A56; d_req = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (d_data_valid) cnt++;
    end
    chk("t5_three_words", cnt, 3);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("t5_async");
    d_req = 1'b0;
    mem_q.delete(); i_q.delete(); d_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_fill(1'b1, 16'h2A56);
    d_req = 1'b1;
    run_until_quiet("t5", 40);

    // 6: I request withdrawn after two issue cycles still completes once
    push_fill(1'b0, 16'h5678);
    i_addr = 16'h5678; i_req = 1'b1;
    repeat (2) @(negedge clk);
    i_req = 1'b0;
    run_until_quiet("t6", 40);
    repeat (3) @(negedge clk);
    chk("t6_no_regrant", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
